// File: rtl/prefetch_line_buffer_pkg.sv
// rtl/prefetch_line_buffer_pkg.sv - default widths, line/entry types and tag helper for the prefetch line buffer
package prefetch_pkg;

    localparam int PFB_ADDR_WIDTH  = 32;
    localparam int PFB_LINE_WIDTH  = 256;
    localparam int PFB_OFFSET_BITS = 5;
    localparam int PFB_DEPTH       = 4;
    localparam int PFB_TAG_WIDTH   = PFB_ADDR_WIDTH - PFB_OFFSET_BITS;

    typedef logic [PFB_LINE_WIDTH-1:0] line_t;
    typedef logic [PFB_TAG_WIDTH-1:0]  tag_t;

    typedef struct packed {
        logic  valid;
        tag_t  tag;
        line_t data;
    } pfb_entry_t;

    function automatic tag_t line_tag(input logic [PFB_ADDR_WIDTH-1:0] addr);
        return addr[PFB_ADDR_WIDTH-1:PFB_OFFSET_BITS];
    endfunction

endpackage

// File: rtl/prefetch_line_buffer_if.sv
// rtl/prefetch_line_buffer_if.sv - fill/lookup/invalidate/response bundle; PREFETCH_LINE_BUFFER_STATS_EN adds counters
interface prefetch_line_buffer_if
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH = PFB_ADDR_WIDTH,
    parameter int LINE_WIDTH = PFB_LINE_WIDTH,
    parameter int DEPTH      = PFB_DEPTH
);
    logic                      fill_valid;
    logic [ADDR_WIDTH-1:0]     fill_addr;
    logic [LINE_WIDTH-1:0]     fill_data;
    logic                      lookup_valid;
    logic [ADDR_WIDTH-1:0]     lookup_addr;
    logic                      lookup_consume;
    logic                      inv_valid;
    logic [ADDR_WIDTH-1:0]     inv_addr;
    logic                      resp_valid;
    logic                      resp_hit;
    logic [LINE_WIDTH-1:0]     resp_data;
    logic [$clog2(DEPTH):0]    count;
    logic                      full;
`ifdef PREFETCH_LINE_BUFFER_STATS_EN
    logic [31:0]               stat_hits;
    logic [31:0]               stat_misses;
    logic [31:0]               stat_evictions;
`endif

    modport master (
        output fill_valid, fill_addr, fill_data,
        output lookup_valid, lookup_addr, lookup_consume,
        output inv_valid, inv_addr,
`ifdef PREFETCH_LINE_BUFFER_STATS_EN
        input  stat_hits, stat_misses, stat_evictions,
`endif
        input  resp_valid, resp_hit, resp_data, count, full
    );

    modport slave (
        input  fill_valid, fill_addr, fill_data,
        input  lookup_valid, lookup_addr, lookup_consume,
        input  inv_valid, inv_addr,
`ifdef PREFETCH_LINE_BUFFER_STATS_EN
        output stat_hits, stat_misses, stat_evictions,
`endif
        output resp_valid, resp_hit, resp_data, count, full
    );

endinterface

// File: rtl/prefetch_line_buffer_entry.sv
// rtl/prefetch_line_buffer_entry.sv - pfb_entry: one tagged line register with set/clear and lookup match
module pfb_entry
    import prefetch_pkg::*;
#(
    parameter int TAG_W  = PFB_TAG_WIDTH,
    parameter int LINE_W = PFB_LINE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              clr,
    input  logic [TAG_W-1:0]  set_tag,
    input  logic [LINE_W-1:0] set_data,
    input  logic [TAG_W-1:0]  cmp_tag,
    output logic              valid,
    output logic [TAG_W-1:0]  tag,
    output logic [LINE_W-1:0] data,
    output logic              match
);

    // set beats clr so a same-edge fill survives a consume of the old copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (set) begin
            valid <= 1'b1;
            tag   <= set_tag;
            data  <= set_data;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

    assign match = valid && (tag == cmp_tag);

endmodule

// File: rtl/prefetch_line_buffer.sv
// rtl/prefetch_line_buffer.sv - multi-entry prefetch line buffer; PREFETCH_LINE_BUFFER_STATS_EN adds hit/miss/eviction counters
module prefetch_line_buffer
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = PFB_ADDR_WIDTH,
    parameter int LINE_WIDTH  = PFB_LINE_WIDTH,
    parameter int OFFSET_BITS = PFB_OFFSET_BITS,
    parameter int DEPTH       = PFB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    prefetch_line_buffer_if.slave  bus
);

    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = IW + 1;

    logic [TAG_W-1:0]      fill_tag, lk_tag, inv_tag;
    logic [DEPTH-1:0]      ent_valid, ent_set, ent_clr, lk_hit, fill_same, inv_hit, next_valid;
    logic [TAG_W-1:0]      ent_tag  [DEPTH];
    logic [LINE_WIDTH-1:0] ent_data [DEPTH];
    logic [LINE_WIDTH-1:0] hit_data;
    logic [IW-1:0]         victim, free_idx, same_idx, place_idx;
    logic [CW-1:0]         next_count;
    logic                  do_fill, evict;
    logic                  unused_offsets;

    assign fill_tag = bus.fill_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign lk_tag   = bus.lookup_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign inv_tag  = bus.inv_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offsets = ^{bus.fill_addr[OFFSET_BITS-1:0], bus.lookup_addr[OFFSET_BITS-1:0],
                              bus.inv_addr[OFFSET_BITS-1:0]};

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        pfb_entry #(.TAG_W(TAG_W), .LINE_W(LINE_WIDTH)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .set      (ent_set[g]),
            .clr      (ent_clr[g]),
            .set_tag  (fill_tag),
            .set_data (bus.fill_data),
            .cmp_tag  (lk_tag),
            .valid    (ent_valid[g]),
            .tag      (ent_tag[g]),
            .data     (ent_data[g]),
            .match    (lk_hit[g])
        );
    end

    always_comb begin
        fill_same = '0;
        inv_hit   = '0;
        hit_data  = '0;
        free_idx  = '0;
        same_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fill_same[i] = ent_valid[i] && (ent_tag[i] == fill_tag);
            inv_hit[i]   = bus.inv_valid && ent_valid[i] && (ent_tag[i] == inv_tag);
            hit_data     = hit_data | (ent_data[i] & {LINE_WIDTH{lk_hit[i]}});
            if (fill_same[i]) same_idx = IW'(i);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) free_idx = IW'(i);
        end
    end

    // A store to the line being filled makes the fill data stale, so it is dropped
    assign do_fill   = bus.fill_valid && !(bus.inv_valid && (inv_tag == fill_tag));
    assign evict     = do_fill && (fill_same == '0) && (&ent_valid);
    assign place_idx = (fill_same != '0) ? same_idx : ((&ent_valid) ? victim : free_idx);

    always_comb begin
        ent_set    = '0;
        ent_clr    = '0;
        next_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_set[i] = do_fill && (place_idx == IW'(i));
            ent_clr[i] = inv_hit[i] || (bus.lookup_valid && bus.lookup_consume && lk_hit[i]);
        end
        next_valid = ent_set | (ent_valid & ~ent_clr);
        for (int i = 0; i < DEPTH; i++) begin
            next_count = next_count + CW'(next_valid[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim         <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            bus.resp_data  <= '0;
            bus.count      <= '0;
            bus.full       <= 1'b0;
        end else begin
            bus.resp_valid <= bus.lookup_valid;
            if (bus.lookup_valid) begin
                bus.resp_hit  <= |lk_hit;
                bus.resp_data <= hit_data;
            end
            if (evict) victim <= victim + IW'(1);
            bus.count <= next_count;
            bus.full  <= (next_count == CW'(DEPTH));
        end
    end

`ifdef PREFETCH_LINE_BUFFER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.stat_hits      <= '0;
            bus.stat_misses    <= '0;
            bus.stat_evictions <= '0;
        end else begin
            if (bus.lookup_valid && (|lk_hit) && (bus.stat_hits != '1))
                bus.stat_hits <= bus.stat_hits + 32'd1;
            if (bus.lookup_valid && !(|lk_hit) && (bus.stat_misses != '1))
                bus.stat_misses <= bus.stat_misses + 32'd1;
            if (evict && (bus.stat_evictions != '1))
                bus.stat_evictions <= bus.stat_evictions + 32'd1;
        end
    end
`endif

endmodule
